axis_bram_reader: RTL and testbench

Initiator-side BRAM port controller that reads a contiguous block of words from the single-port BRAM in the axis_bram subsystem and streams them out as AXI4-Stream master beats. It absorbs the BRAM's one-cycle read latency and downstream backpressure with a two-entry output buffer, sustaining one beat per clock when `m_axis_tready` is held high. It drives the BRAM port directly, in place of a DMA or processor initiator, and sits between that BRAM and any AXIS consumer.

---
 rtl/axis_bram_reader.sv | 175 +++++++++++++++++
 tb/tb_axis_bram_reader.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_reader.sv
// axis_bram_reader
// Reads a contiguous block of words from a single-port BRAM (one-cycle read
// latency) and streams them out as AXI4-Stream master beats.
//
// Ports:
//   clk, reset_n          clock and synchronous active-low reset
//   start, base_addr,     transfer request; base_addr/length captured when
//   length                start is accepted in IDLE
//   busy, done            busy from accepted start until done; done is a
//                         one-cycle completion pulse
//   bram_*                BRAM port (read-only: we/din tied to zero)
//   m_axis_*              AXI4-Stream master (tdata/tvalid/tready/tlast)
//
// A two-entry output buffer absorbs the read latency and downstream
// backpressure. A read is only issued if its data is guaranteed a free slot
// when it returns, so nothing is ever dropped and one beat per clock is
// sustained while tready is held high.
module axis_bram_reader #(
    parameter int C_AXIS_BRAM_ADDR_WIDTH = 12,
    parameter int C_AXIS_BRAM_DATA_WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   base_addr,
    input  logic [C_AXIS_BRAM_ADDR_WIDTH:0]     length,
    output logic                                busy,
    output logic                                done,
    output logic                                bram_clk,
    output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   bram_addr,
    output logic                                bram_en,
    output logic [C_AXIS_BRAM_DATA_WIDTH/8-1:0] bram_we,
    output logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   bram_din,
    input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   bram_dout,
    output logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast
);

    localparam int AW = C_AXIS_BRAM_ADDR_WIDTH;
    localparam int DW = C_AXIS_BRAM_DATA_WIDTH;
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   issued_q, issued_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;
    logic [DW-1:0]   buf_data_q [0:1];
    logic [DW-1:0]   buf_data_d [0:1];
    logic            buf_last_q [0:1];
    logic            buf_last_d [0:1];
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [1:0]      occ_q, occ_d;

    logic            pop;
    logic            push;
    logic            issue;
    logic [2:0]      pending;

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        len_d           = len_q;
        issued_d        = issued_q;
        buf_data_d      = buf_data_q;
        buf_last_d      = buf_last_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;

        pop  = (occ_q != 2'd0) && m_axis_tready;
        push = inflight_q;

        // Entries that will occupy the buffer after this edge, before any new
        // issue. Issue only if the returning word is sure to find a slot.
        pending = {1'b0, occ_q} + {2'b00, inflight_q};
        issue   = (state_q == S_RUN) && (issued_q < len_q) &&
                  (pending < (3'd2 + {2'b00, pop}));

        inflight_d      = issue;
        inflight_last_d = issue && (issued_q == (len_q - LW'(1)));
        if (issue) begin
            issued_d = issued_q + LW'(1);
        end

        // bram_dout is only meaningful the cycle after an issued read.
        if (push) begin
            buf_data_d[wr_ptr_q] = bram_dout;
            buf_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    state_d  = (length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pop && buf_last_q[rd_ptr_q]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            occ_q           <= 2'd0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            occ_q           <= occ_d;
        end
    end

    // Buffer entries are cleared on reset so tdata reads zero afterwards.
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                buf_data_q[gi] <= '0;
                buf_last_q[gi] <= 1'b0;
            end else begin
                buf_data_q[gi] <= buf_data_d[gi];
                buf_last_q[gi] <= buf_last_d[gi];
            end
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign bram_clk      = clk;
    // Truncating issued to AW bits makes the address wrap past top of memory.
    assign bram_addr     = base_q + issued_q[AW-1:0];
    assign bram_en       = issue;
    assign bram_we       = '0;
    assign bram_din      = '0;
    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = buf_data_q[rd_ptr_q];
    // Stale last flags of popped entries must not leak out while idle.
    assign m_axis_tlast  = m_axis_tvalid && buf_last_q[rd_ptr_q];

endmodule

// File: tb/tb_axis_bram_reader.sv
module tb_axis_bram_reader;

    localparam int AW = 12;
    localparam int DW = 64;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     length;
    logic            busy;
    logic            done;
    logic            bram_clk;
    logic [AW-1:0]   bram_addr;
    logic            bram_en;
    logic [DW/8-1:0] bram_we;
    logic [DW-1:0]   bram_din;
    logic [DW-1:0]   bram_dout;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;

    axis_bram_reader #(
        .C_AXIS_BRAM_ADDR_WIDTH(AW),
        .C_AXIS_BRAM_DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .bram_clk     (bram_clk),
        .bram_addr    (bram_addr),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_din     (bram_din),
        .bram_dout    (bram_dout),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency, all-ones when not enabled.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        bram_dout <= bram_en ? mem[bram_addr] : '1;
    end

    // Monitor: records beats and issued addresses, and counts protocol
    // violations. Sampled on the falling edge, inputs change after rising.
    logic [DW:0]   beat_q [$];
    logic [AW-1:0] addr_q [$];
    int            we_bad, stall_bad, ovf_bad, en_seen, valid_seen;
    int            en_total, pop_total;
    logic          stall_prev;
    logic [DW-1:0] data_prev;
    logic          last_prev;

    initial begin
        we_bad = 0; stall_bad = 0; ovf_bad = 0; en_seen = 0; valid_seen = 0;
        en_total = 0; pop_total = 0; stall_prev = 1'b0;
        data_prev = '0; last_prev = 1'b0;
    end

    always @(negedge clk) begin
        if (bram_we != '0 || bram_din != '0) we_bad <= we_bad + 1;
        if (!reset_n) begin
            en_total   <= 0;
            pop_total  <= 0;
            stall_prev <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                beat_q.push_back({m_axis_tlast, m_axis_tdata});
            if (bram_en) addr_q.push_back(bram_addr);
            if (bram_en) en_seen <= en_seen + 1;
            if (m_axis_tvalid) valid_seen <= valid_seen + 1;
            if ((en_total + int'(bram_en)) -
                (pop_total + int'(m_axis_tvalid && m_axis_tready)) > 2)
                ovf_bad <= ovf_bad + 1;
            en_total  <= en_total + int'(bram_en);
            pop_total <= pop_total + int'(m_axis_tvalid && m_axis_tready);
            if (stall_prev && (!m_axis_tvalid || m_axis_tdata != data_prev ||
                               m_axis_tlast != last_prev))
                stall_bad <= stall_bad + 1;
            stall_prev <= m_axis_tvalid && !m_axis_tready;
            data_prev  <= m_axis_tdata;
            last_prev  <= m_axis_tlast;
        end
    end

    int pass_cnt;
    int total_cnt;

    // Pulses start for one cycle; returns just after the accepting edge E0,
    // so the next falling edge is in the cycle after E0.
    task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({busy, done, bram_en, m_axis_tvalid, m_axis_tlast} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b want 00000",
                     {busy, done, bram_en, m_axis_tvalid, m_axis_tlast});
        end else pass_cnt++;
        total_cnt++;
        if (m_axis_tdata !== '0 || bram_addr !== '0) begin
            $display("FAIL reset_data: tdata %h addr %h want 0", m_axis_tdata, bram_addr);
        end else pass_cnt++;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int b0, first_valid, done_c, busy_fall, done_cnt;
        logic en0;
        logic [AW-1:0] addr0;
        logic [DW:0] exp;
        b0 = beat_q.size();
        first_valid = -1; done_c = -1; busy_fall = -1; done_cnt = 0;
        en0 = 1'b0; addr0 = '0;
        m_axis_tready = 1'b1;
        launch(12'd2, 13'd4);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin en0 = bram_en; addr0 = bram_addr; end
            if (m_axis_tvalid && first_valid < 0) first_valid = c;
            if (done) begin done_cnt++; if (done_c < 0) done_c = c; end
            if (!busy && busy_fall < 0) busy_fall = c;
        end
        total_cnt++;
        if (en0 !== 1'b1 || addr0 !== 12'd2) begin
            $display("FAIL basic_first_read: en %b addr %h want 1 002", en0, addr0);
        end else pass_cnt++;
        total_cnt++;
        if (first_valid != 2) begin
            $display("FAIL basic_first_valid: cycle %0d want 2", first_valid);
        end else pass_cnt++;
        total_cnt++;
        if (done_c != 6 || done_cnt != 1) begin
            $display("FAIL basic_done: cycle %0d width %0d want 6 1", done_c, done_cnt);
        end else pass_cnt++;
        total_cnt++;
        if (busy_fall != 7) begin
            $display("FAIL basic_busy_fall: cycle %0d want 7", busy_fall);
        end else pass_cnt++;
        total_cnt++;
        if (beat_q.size() - b0 != 4) begin
            $display("FAIL basic_count: beats %0d want 4", beat_q.size() - b0);
        end else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp = {(i == 3), 64'h102 + 64'(i)};
            total_cnt++;
            if (beat_q[b0 + i] !== exp) begin
                $display("FAIL basic_beat%0d: got %h want %h", i, beat_q[b0 + i], exp);
            end else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        int b0, a0;
        logic [AW-1:0] exp_addr [4];
        logic [DW-1:0] exp_data [4];
        exp_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        exp_data = '{64'h10FE, 64'h10FF, 64'h100, 64'h101};
        b0 = beat_q.size(); a0 = addr_q.size();
        m_axis_tready = 1'b1;
        launch(12'hFFE, 13'd4);
        repeat (10) @(negedge clk);
        total_cnt++;
        if (addr_q.size() - a0 != 4 || beat_q.size() - b0 != 4) begin
            $display("FAIL wrap_count: reads %0d beats %0d want 4 4",
                     addr_q.size() - a0, beat_q.size() - b0);
        end else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (addr_q[a0 + i] !== exp_addr[i] || beat_q[b0 + i][DW-1:0] !== exp_data[i]) begin
                $display("FAIL wrap_%0d: addr %h data %h want %h %h", i,
                         addr_q[a0 + i], beat_q[b0 + i][DW-1:0], exp_addr[i], exp_data[i]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int b0, st0, ov0, bad;
        logic saw_done;
        logic [15:0] pat;
        logic [DW:0] exp;
        pat = 16'b1011_0010_1110_0100;
        b0 = beat_q.size(); st0 = stall_bad; ov0 = ovf_bad;
        saw_done = 1'b0; bad = 0;
        m_axis_tready = 1'b0;
        launch(12'h020, 13'd16);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            m_axis_tready = pat[c % 16];
            @(negedge clk);
            if (done) begin saw_done = 1'b1; break; end
        end
        m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (saw_done !== 1'b1) begin
            $display("FAIL bp_timeout: done %b want 1", saw_done);
        end else pass_cnt++;
        total_cnt++;
        if (beat_q.size() - b0 != 16) begin
            $display("FAIL bp_count: beats %0d want 16", beat_q.size() - b0);
        end else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            exp = {(i == 15), 64'h120 + 64'(i)};
            if (beat_q[b0 + i] !== exp) begin
                bad++;
                $display("FAIL bp_beat%0d: got %h want %h", i, beat_q[b0 + i], exp);
            end
        end
        total_cnt++;
        if (bad != 0) begin
            $display("FAIL bp_order: bad beats %0d want 0", bad);
        end else pass_cnt++;
        total_cnt++;
        if (stall_bad - st0 != 0) begin
            $display("FAIL bp_stable: violations %0d want 0", stall_bad - st0);
        end else pass_cnt++;
        total_cnt++;
        if (ovf_bad - ov0 != 0) begin
            $display("FAIL bp_outstanding: violations %0d want 0", ovf_bad - ov0);
        end else pass_cnt++;
    endtask

    task automatic test_zero_len();
        int e0, v0;
        e0 = en_seen; v0 = valid_seen;
        m_axis_tready = 1'b1;
        launch(12'h010, 13'd0);
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL zero_done: done %b busy %b want 1 1", done, busy);
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL zero_idle: done %b busy %b want 0 0", done, busy);
        end else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (en_seen - e0 != 0 || valid_seen - v0 != 0) begin
            $display("FAIL zero_activity: en %0d valid %0d want 0 0",
                     en_seen - e0, valid_seen - v0);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int b0;
        m_axis_tready = 1'b0;
        launch(12'h000, 13'd8);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (m_axis_tvalid !== 1'b1) begin
            $display("FAIL rstmid_pre: tvalid %b want 1", m_axis_tvalid);
        end else pass_cnt++;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, bram_en, m_axis_tvalid, m_axis_tlast} !== 5'b0 ||
            m_axis_tdata !== '0 || bram_addr !== '0) begin
            $display("FAIL rstmid_outputs: ctrl %b tdata %h addr %h want 0",
                     {busy, done, bram_en, m_axis_tvalid, m_axis_tlast}, m_axis_tdata, bram_addr);
        end else pass_cnt++;
        m_axis_tready = 1'b1;
        b0 = beat_q.size();
        repeat (4) @(negedge clk);
        total_cnt++;
        if (beat_q.size() - b0 != 0) begin
            $display("FAIL rstmid_stale: beats %0d want 0", beat_q.size() - b0);
        end else pass_cnt++;
        launch(12'h004, 13'd2);
        repeat (8) @(negedge clk);
        total_cnt++;
        if (beat_q.size() - b0 != 2 || beat_q[b0] !== {1'b0, 64'h104} ||
            beat_q[b0 + 1] !== {1'b1, 64'h105}) begin
            $display("FAIL rstmid_restart: n %0d b0 %h b1 %h want 2 0104 1105",
                     beat_q.size() - b0, beat_q[b0], beat_q[b0 + 1]);
        end else pass_cnt++;
    endtask

    task automatic test_start_busy();
        int b0, a0, done_cnt, busy_last;
        logic done6;
        b0 = beat_q.size(); a0 = addr_q.size();
        done_cnt = 0; done6 = 1'b0; busy_last = 0;
        m_axis_tready = 1'b1;
        launch(12'h000, 13'd4);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (c == 6) done6 = done;
            if (c >= 7 && busy) busy_last++;
            @(posedge clk); #1;
            // Second request lands in a RUN cycle (c=1) and the DONE cycle (c=6).
            start = (c == 0 || c == 5);
            base_addr = 12'h040;
            length = 13'd2;
        end
        start = 1'b0;
        total_cnt++;
        if (addr_q.size() - a0 != 4) begin
            $display("FAIL busy_reads: %0d want 4", addr_q.size() - a0);
        end else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (addr_q[a0 + i] !== 12'(i) || beat_q[b0 + i] !== {(i == 3), 64'h100 + 64'(i)}) begin
                $display("FAIL busy_beat%0d: addr %h beat %h want %h %h", i,
                         addr_q[a0 + i], beat_q[b0 + i], 12'(i), {(i == 3), 64'h100 + 64'(i)});
            end else pass_cnt++;
        end
        total_cnt++;
        if (done6 !== 1'b1 || done_cnt != 1 || busy_last != 0 || beat_q.size() - b0 != 4) begin
            $display("FAIL busy_ignored: done6 %b dones %0d busy_after %0d beats %0d want 1 1 0 4",
                     done6, done_cnt, busy_last, beat_q.size() - b0);
        end else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 64'h100 + 64'(i);

        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_start_busy();

        total_cnt++;
        if (we_bad != 0) begin
            $display("FAIL bram_we_zero: violations %0d want 0", we_bad);
        end else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
